// File: rtl/fsic_gpio_pkg.sv
// Shared definitions for the GPIO pad controller: pad mode encodings, pad DM
// drive codes, register addresses and STATUS field layout.
package fsic_gpio_pkg;

  localparam int unsigned CFG_AW = 3;
  localparam int unsigned CFG_DW = 32;

  // Per-pad mode as programmed in the MODE register (2 bits per pad)
  typedef enum logic [1:0] {
    MODE_INPUT    = 2'b00,
    MODE_PULLUP   = 2'b01,
    MODE_PULLDOWN = 2'b10,
    MODE_OUTPUT   = 2'b11
  } pad_mode_e;

  // gpiov2 DM[2:0] drive codes
  localparam logic [2:0] DM_INPUT    = 3'b001;
  localparam logic [2:0] DM_PULLUP   = 3'b010;
  localparam logic [2:0] DM_PULLDOWN = 3'b011;
  localparam logic [2:0] DM_OUTPUT   = 3'b110;

  // Register map
  localparam logic [CFG_AW-1:0] ADDR_OUT     = 3'd0;
  localparam logic [CFG_AW-1:0] ADDR_MODE    = 3'd1;
  localparam logic [CFG_AW-1:0] ADDR_IN      = 3'd2;
  localparam logic [CFG_AW-1:0] ADDR_RISE_EN = 3'd3;
  localparam logic [CFG_AW-1:0] ADDR_FALL_EN = 3'd4;
  localparam logic [CFG_AW-1:0] ADDR_STATUS  = 3'd5;

  // STATUS bit offsets: rise flags in the low half, fall flags in the high half
  localparam int unsigned STATUS_RISE_OFS = 0;
  localparam int unsigned STATUS_FALL_OFS = 16;

  // Control pins presented to one pad wrapper
  typedef struct packed {
    logic [2:0] dm;
    logic       oe_n;
  } pad_ctrl_t;

  // Mode -> pad control pins; only OUTPUT enables the driver
  function automatic pad_ctrl_t mode_encode(input pad_mode_e mode);
    pad_ctrl_t ctrl;
    ctrl.dm   = DM_INPUT;
    ctrl.oe_n = 1'b1;
    case (mode)
      MODE_PULLUP:   ctrl.dm = DM_PULLUP;
      MODE_PULLDOWN: ctrl.dm = DM_PULLDOWN;
      MODE_OUTPUT: begin
        ctrl.dm   = DM_OUTPUT;
        ctrl.oe_n = 1'b0;
      end
      default: ;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/fsic_gpio_in_filter.sv
// Input conditioning for one pad: synchronizer chain, debounce counter and
// one-cycle edge indications aligned with the debounced value update.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   pad_in_i       raw pad IN pin, asynchronous
//   deb_o          debounced level (registered)
//   rise_c_o       high in the cycle before deb_o goes 0->1
//   fall_c_o       high in the cycle before deb_o goes 1->0
module fsic_gpio_in_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_in_i,
  output logic deb_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  // Bypass (0) behaves as a one-sample debounce
  localparam int unsigned DEB_LAST = (DEB_CYCLES == 0) ? 0 : DEB_CYCLES - 1;
  localparam int unsigned CNT_W    = (DEB_LAST > 0) ? $clog2(DEB_LAST + 1) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   synced_c;
  logic                   flip_c;

  assign synced_c = sync_q[SYNC_STAGES-1];
  assign flip_c   = (synced_c != deb_q) && (cnt_q == CNT_W'(DEB_LAST));

  // Counter tracks consecutive cycles the synced value disagrees with deb
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_in_i};
    cnt_d  = '0;
    deb_d  = deb_q;
    if (synced_c != deb_q) begin
      if (flip_c) begin
        deb_d = synced_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_o    = deb_q;
  assign rise_c_o = flip_c & synced_c;
  assign fall_c_o = flip_c & ~synced_c;

endmodule

// File: rtl/fsic_gpio_pad_ctrl.sv
// Core-side GPIO pad controller: register file, per-pad mode encode onto
// DM/OE_N, conditioned pad inputs, sticky edge STATUS and level interrupt.
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   cfg_wr_i/rd_i/addr_i/wdata_i register access strobes, index, write data
//   cfg_rdata_o, cfg_rvalid_o    read data, valid one cycle after cfg_rd_i
//   pad_dm_o, pad_oe_n_o         pad drive mode and output enable (from MODE)
//   pad_inp_dis_o, pad_out_o     input disable (always 0), OUT register
//   pad_in_i                     pad inputs, asynchronous
//   irq_o                        OR of enabled STATUS bits, registered
module fsic_gpio_pad_ctrl
  import fsic_gpio_pkg::*;
#(
  parameter int unsigned NUM_PADS    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cfg_wr_i,
  input  logic                  cfg_rd_i,
  input  logic [CFG_AW-1:0]     cfg_addr_i,
  input  logic [CFG_DW-1:0]     cfg_wdata_i,
  output logic [CFG_DW-1:0]     cfg_rdata_o,
  output logic                  cfg_rvalid_o,
  output logic [3*NUM_PADS-1:0] pad_dm_o,
  output logic [NUM_PADS-1:0]   pad_oe_n_o,
  output logic [NUM_PADS-1:0]   pad_inp_dis_o,
  output logic [NUM_PADS-1:0]   pad_out_o,
  input  logic [NUM_PADS-1:0]   pad_in_i,
  output logic                  irq_o
);

  logic [NUM_PADS-1:0]   out_q, out_d;
  logic [2*NUM_PADS-1:0] mode_q, mode_d;
  logic [NUM_PADS-1:0]   rise_en_q, rise_en_d;
  logic [NUM_PADS-1:0]   fall_en_q, fall_en_d;
  logic [NUM_PADS-1:0]   rise_q, rise_d;
  logic [NUM_PADS-1:0]   fall_q, fall_d;
  logic                  irq_q, irq_d;
  logic                  rvalid_q, rvalid_d;
  logic [CFG_DW-1:0]     rdata_q, rdata_d;
  logic [CFG_DW-1:0]     rd_val_c;
  logic [NUM_PADS-1:0]   pad_in_deb;
  logic [NUM_PADS-1:0]   rise_set_c;
  logic [NUM_PADS-1:0]   fall_set_c;
  logic                  unused_wdata_c;

  // Upper write-data bits beyond the implemented fields are don't-care
  assign unused_wdata_c = ^cfg_wdata_i;

  // Per-pad input conditioning and combinational mode encode.
  // DM and OE_N come from the same MODE bits, so they switch together.
  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    pad_ctrl_t ctrl_c;

    fsic_gpio_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_in_filter (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .pad_in_i (pad_in_i[g]),
      .deb_o    (pad_in_deb[g]),
      .rise_c_o (rise_set_c[g]),
      .fall_c_o (fall_set_c[g])
    );

    assign ctrl_c              = mode_encode(pad_mode_e'(mode_q[2*g +: 2]));
    assign pad_dm_o[3*g +: 3]  = ctrl_c.dm;
    assign pad_oe_n_o[g]       = ctrl_c.oe_n;
  end

  // Read mux on current (pre-write) register contents
  always_comb begin
    rd_val_c = '0;
    case (cfg_addr_i)
      ADDR_OUT:     rd_val_c = CFG_DW'(out_q);
      ADDR_MODE:    rd_val_c = CFG_DW'(mode_q);
      ADDR_IN:      rd_val_c = CFG_DW'(pad_in_deb);
      ADDR_RISE_EN: rd_val_c = CFG_DW'(rise_en_q);
      ADDR_FALL_EN: rd_val_c = CFG_DW'(fall_en_q);
      ADDR_STATUS:  rd_val_c = (CFG_DW'(rise_q) << STATUS_RISE_OFS)
                             | (CFG_DW'(fall_q) << STATUS_FALL_OFS);
      default:      rd_val_c = '0;
    endcase
  end

  // Register writes; a new edge wins over a same-cycle W1C of its bit
  always_comb begin
    out_d     = out_q;
    mode_d    = mode_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    rise_d    = rise_q | rise_set_c;
    fall_d    = fall_q | fall_set_c;
    if (cfg_wr_i) begin
      case (cfg_addr_i)
        ADDR_OUT:     out_d     = cfg_wdata_i[NUM_PADS-1:0];
        ADDR_MODE:    mode_d    = cfg_wdata_i[2*NUM_PADS-1:0];
        ADDR_RISE_EN: rise_en_d = cfg_wdata_i[NUM_PADS-1:0];
        ADDR_FALL_EN: fall_en_d = cfg_wdata_i[NUM_PADS-1:0];
        ADDR_STATUS: begin
          rise_d = (rise_q & ~cfg_wdata_i[STATUS_RISE_OFS +: NUM_PADS]) | rise_set_c;
          fall_d = (fall_q & ~cfg_wdata_i[STATUS_FALL_OFS +: NUM_PADS]) | fall_set_c;
        end
        default: ;
      endcase
    end
    irq_d    = |((rise_q & rise_en_q) | (fall_q & fall_en_q));
    rvalid_d = cfg_rd_i;
    rdata_d  = cfg_rd_i ? rd_val_c : rdata_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_q     <= '0;
      mode_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      irq_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      mode_q    <= mode_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      irq_q     <= irq_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cfg_rdata_o   = rdata_q;
  assign cfg_rvalid_o  = rvalid_q;
  assign pad_inp_dis_o = '0;
  assign pad_out_o     = out_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_fsic_gpio_pad_ctrl.sv
// Self-checking bench for fsic_gpio_pad_ctrl: register/encode vector table,
// directed multi-cycle sequences and a randomized run against a reference model.
module tb_fsic_gpio_pad_ctrl;

  localparam int unsigned N      = 8;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned DEB    = 4;
  localparam int unsigned DEBE   = (DEB == 0) ? 1 : DEB;
  localparam int unsigned HQ_LEN = SYNC + DEBE + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [2:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic [N-1:0]  pad_in = '0;
  logic [31:0]   rdata;
  logic          rvalid;
  logic [3*N-1:0] dm;
  logic [N-1:0]  oe_n;
  logic [N-1:0]  inp_dis;
  logic [N-1:0]  pout;
  logic          irq;

  fsic_gpio_pad_ctrl #(
    .NUM_PADS    (N),
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .cfg_wr_i      (wr),
    .cfg_rd_i      (rd),
    .cfg_addr_i    (addr),
    .cfg_wdata_i   (wdata),
    .cfg_rdata_o   (rdata),
    .cfg_rvalid_o  (rvalid),
    .pad_dm_o      (dm),
    .pad_oe_n_o    (oe_n),
    .pad_inp_dis_o (inp_dis),
    .pad_out_o     (pout),
    .pad_in_i      (pad_in),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [N-1:0]   m_out, m_ren, m_fen, m_in, m_rise, m_fall;
  logic [2*N-1:0] m_mode;
  logic           m_irq, m_rvalid;
  logic [31:0]    m_rdata;
  logic [N-1:0]   hq[$];  // pad_in samples, one per clock edge, newest last

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_out);
      3'd1: return 32'(m_mode);
      3'd2: return 32'(m_in);
      3'd3: return 32'(m_ren);
      3'd4: return 32'(m_fen);
      3'd5: return 32'(m_rise) | (32'(m_fall) << 16);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3*N-1:0] exp_dm(input logic [2*N-1:0] md);
    logic [3*N-1:0] r;
    logic [1:0]     m;
    r = '0;
    for (int p = 0; p < N; p++) begin
      m = md[2*p +: 2];
      case (m)
        2'b00:   r[3*p +: 3] = 3'b001;
        2'b01:   r[3*p +: 3] = 3'b010;
        2'b10:   r[3*p +: 3] = 3'b011;
        default: r[3*p +: 3] = 3'b110;
      endcase
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_oe_n(input logic [2*N-1:0] md);
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = (md[2*p +: 2] != 2'b11);
    return r;
  endfunction

  // Debounced value flips once the last DEBE synced samples (the pad value
  // seen SYNC edges earlier) all disagree with it.
  task automatic model_edge();
    logic [N-1:0] rset, fset, nin;
    logic         diff;
    int           top;
    if (rst) begin
      m_out = '0; m_mode = '0; m_ren = '0; m_fen = '0; m_in = '0;
      m_rise = '0; m_fall = '0; m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      hq.delete();
      repeat (HQ_LEN) hq.push_back('0);
      return;
    end
    hq.push_back(pad_in);
    if (hq.size() > HQ_LEN) void'(hq.pop_front());
    top  = hq.size() - 1 - int'(SYNC);
    nin  = m_in;
    rset = '0;
    fset = '0;
    for (int p = 0; p < N; p++) begin
      diff = 1'b1;
      for (int k = 0; k < int'(DEBE); k++)
        if (hq[top-k][p] == m_in[p]) diff = 1'b0;
      if (diff) begin
        nin[p] = ~m_in[p];
        if (nin[p]) rset[p] = 1'b1;
        else        fset[p] = 1'b1;
      end
    end
    m_rvalid = rd;
    if (rd) m_rdata = m_read(addr);
    m_irq = |((m_rise & m_ren) | (m_fall & m_fen));
    if (wr && addr == 3'd5) begin
      m_rise = m_rise & ~wdata[N-1:0];
      m_fall = m_fall & ~wdata[16 +: N];
    end
    m_rise = m_rise | rset;
    m_fall = m_fall | fset;
    m_in   = nin;
    if (wr) begin
      case (addr)
        3'd0: m_out  = wdata[N-1:0];
        3'd1: m_mode = wdata[2*N-1:0];
        3'd3: m_ren  = wdata[N-1:0];
        3'd4: m_fen  = wdata[N-1:0];
        default: ;
      endcase
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; pad_in = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    step();
    rd = 1'b0;
    chk({name, "_rvalid"}, 32'(rvalid), 32'h1);
    chk(name, rdata, exp);
  endtask

  task automatic cmp_model();
    chk("rnd_dm", 32'(dm), 32'(exp_dm(m_mode)));
    chk("rnd_oe_n", 32'(oe_n), 32'(exp_oe_n(m_mode)));
    chk("rnd_out", 32'(pout), 32'(m_out));
    chk("rnd_inp_dis", 32'(inp_dis), 32'h0);
    chk("rnd_irq", 32'(irq), 32'(m_irq));
    chk("rnd_rvalid", 32'(rvalid), 32'(m_rvalid));
    if (m_rvalid) chk("rnd_rdata", rdata, m_rdata);
  endtask

  // ---------------- register / encode vector table ----------------
  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [23:0] dm;
    logic [7:0]  oe_n;
    logic [7:0]  out;
    logic        rvalid;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mkvec(input logic w, input logic r, input logic [2:0] a,
                                 input logic [31:0] d, input logic [23:0] edm,
                                 input logic [7:0] eoe, input logic [7:0] eout,
                                 input logic erv, input logic [31:0] erd);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = a; v.wdata = d; v.dm = edm; v.oe_n = eoe;
    v.out = eout; v.rvalid = erv; v.rdata = erd;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];

    // 1: reset state
    do_reset();
    chk("rst_dm", 32'(dm), 32'h0024_9249);
    chk("rst_oe_n", 32'(oe_n), 32'hFF);
    chk("rst_out", 32'(pout), 32'h0);
    chk("rst_inp_dis", 32'(inp_dis), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    rd_chk("rst_status", 3'd5, 32'h0);

    // 2: mode encode, OUT, readback, same-cycle write+read, unmapped/upper bits
    vecs.push_back(mkvec(1, 0, 3'd1, 32'h0000_E4E4, 24'hCD1CD1, 8'h77, 8'h00, 0, 32'h0));
    vecs.push_back(mkvec(1, 0, 3'd0, 32'h0000_0008, 24'hCD1CD1, 8'h77, 8'h08, 0, 32'h0));
    vecs.push_back(mkvec(0, 1, 3'd1, 32'h0,         24'hCD1CD1, 8'h77, 8'h08, 1, 32'h0000_E4E4));
    vecs.push_back(mkvec(0, 1, 3'd0, 32'h0,         24'hCD1CD1, 8'h77, 8'h08, 1, 32'h0000_0008));
    vecs.push_back(mkvec(1, 1, 3'd1, 32'h0,         24'h249249, 8'hFF, 8'h08, 1, 32'h0000_E4E4));
    vecs.push_back(mkvec(0, 1, 3'd1, 32'h0,         24'h249249, 8'hFF, 8'h08, 1, 32'h0));
    vecs.push_back(mkvec(1, 0, 3'd1, 32'hFFFF_FFFF, 24'hDB6DB6, 8'h00, 8'h08, 0, 32'h0));
    vecs.push_back(mkvec(0, 1, 3'd1, 32'h0,         24'hDB6DB6, 8'h00, 8'h08, 1, 32'h0000_FFFF));
    vecs.push_back(mkvec(1, 0, 3'd6, 32'hFFFF_FFFF, 24'hDB6DB6, 8'h00, 8'h08, 0, 32'h0));
    vecs.push_back(mkvec(0, 1, 3'd6, 32'h0,         24'hDB6DB6, 8'h00, 8'h08, 1, 32'h0));
    vecs.push_back(mkvec(0, 1, 3'd7, 32'h0,         24'hDB6DB6, 8'h00, 8'h08, 1, 32'h0));
    vecs.push_back(mkvec(1, 0, 3'd3, 32'hFFFF_FFFF, 24'hDB6DB6, 8'h00, 8'h08, 0, 32'h0));
    vecs.push_back(mkvec(0, 1, 3'd3, 32'h0,         24'hDB6DB6, 8'h00, 8'h08, 1, 32'h0000_00FF));
    vecs.push_back(mkvec(1, 0, 3'd1, 32'h0000_00E4, 24'h249CD1, 8'hF7, 8'h08, 0, 32'h0));
    vecs.push_back(mkvec(1, 0, 3'd0, 32'h0,         24'h249CD1, 8'hF7, 8'h00, 0, 32'h0));
    for (int i = 0; i < vecs.size(); i++) begin
      wr = vecs[i].wr; rd = vecs[i].rd; addr = vecs[i].addr; wdata = vecs[i].wdata;
      step();
      wr = 1'b0; rd = 1'b0;
      chk($sformatf("vec%0d_dm", i), 32'(dm), 32'(vecs[i].dm));
      chk($sformatf("vec%0d_oe_n", i), 32'(oe_n), 32'(vecs[i].oe_n));
      chk($sformatf("vec%0d_out", i), 32'(pout), 32'(vecs[i].out));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'h0);
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].rvalid));
      if (vecs[i].rvalid) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
    end

    // 3: 3-cycle glitch ignored; held input lands in IN exactly 6 cycles later
    do_reset();
    pad_in[2] = 1'b1;
    repeat (3) step();
    pad_in[2] = 1'b0;
    repeat (8) step();
    rd_chk("glitch_in", 3'd2, 32'h0);
    rd_chk("glitch_status", 3'd5, 32'h0);
    pad_in[2] = 1'b1;
    repeat (5) step();
    rd_chk("deb_in_cycle6", 3'd2, 32'h0);
    rd_chk("deb_in_cycle7", 3'd2, 32'h4);
    rd_chk("deb_rise_status", 3'd5, 32'h4);

    // 4: irq timing, W1C, disabled fall edge
    do_reset();
    wr_reg(3'd3, 32'h4);
    pad_in[2] = 1'b1;
    repeat (6) step();
    chk("irq_before", 32'(irq), 32'h0);
    step();
    chk("irq_set", 32'(irq), 32'h1);
    wr_reg(3'd5, 32'h4);
    chk("irq_w1c_edge", 32'(irq), 32'h1);
    step();
    chk("irq_cleared", 32'(irq), 32'h0);
    pad_in[2] = 1'b0;
    repeat (10) step();
    chk("irq_fall_disabled", 32'(irq), 32'h0);
    rd_chk("fall_status", 3'd5, 32'h0004_0000);

    // 5: rising edge coinciding with W1C of the same bit
    do_reset();
    pad_in[0] = 1'b1;
    repeat (8) step();
    pad_in[0] = 1'b0;
    repeat (8) step();
    pad_in[0] = 1'b1;
    repeat (5) step();
    wr = 1'b1; addr = 3'd5; wdata = 32'h1;
    step();
    wr = 1'b0;
    rd_chk("collide_status", 3'd5, 32'h0001_0001);
    wr_reg(3'd5, 32'h1);
    rd_chk("w1c_status", 3'd5, 32'h0001_0000);

    // 6: reset mid-debounce with STATUS pending
    do_reset();
    pad_in[0] = 1'b1;
    repeat (8) step();
    pad_in[0] = 1'b0;
    pad_in[2] = 1'b1;
    repeat (8) step();
    wr_reg(3'd5, 32'h1);
    rd_chk("pre_rst_status", 3'd5, 32'h0001_0004);
    wr_reg(3'd3, 32'h4);
    wr_reg(3'd1, 32'hFFFF);
    wr_reg(3'd0, 32'hFF);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    pad_in = 8'hF4;
    repeat (4) step();
    rst = 1'b1; pad_in = '0;
    step();
    chk("mid_rst_dm", 32'(dm), 32'h0024_9249);
    chk("mid_rst_oe_n", 32'(oe_n), 32'hFF);
    chk("mid_rst_out", 32'(pout), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    rst = 1'b0;
    wr_reg(3'd3, 32'hFF);
    wr_reg(3'd4, 32'hFF);
    repeat (10) step();
    chk("post_rst_irq", 32'(irq), 32'h0);
    rd_chk("post_rst_status", 3'd5, 32'h0);
    rd_chk("post_rst_in", 3'd2, 32'h0);

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 499) == 0);
      wr    = ($urandom_range(0, 3) == 0);
      rd    = ($urandom_range(0, 2) == 0);
      addr  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      for (int p = 0; p < int'(N); p++)
        if ($urandom_range(0, 11) == 0) pad_in[p] = ~pad_in[p];
      step();
      cmp_model();
    end
    rst = 1'b0; wr = 1'b0; rd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
